// File: rtl/lc3_pkg.sv
// Shared LC-3 constants, widths and payload types for the operand-fetch stage.
package lc3_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned REG_W  = $clog2(NREG);
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned ALUK_W = 2;
  localparam int unsigned NZP_W  = 3;

  localparam logic [OPC_W-1:0]  OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0]  OP_AND = 4'b0101;
  localparam logic [OPC_W-1:0]  OP_NOT = 4'b1001;

  localparam logic [ALUK_W-1:0] ALUK_ADD = 2'b00;
  localparam logic [ALUK_W-1:0] ALUK_AND = 2'b01;
  localparam logic [ALUK_W-1:0] ALUK_NOT = 2'b10;

  localparam logic [NZP_W-1:0]  NZP_RESET = 3'b010;

  // Decoded operation handed to the ALU.
  typedef struct packed {
    logic [ALUK_W-1:0] aluk;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  dr;
  } alu_op_t;

  // Condition codes for a value being written back.
  function automatic logic [NZP_W-1:0] nzp_of(input logic [DATA_W-1:0] value);
    if (value[DATA_W-1])   return 3'b100;
    else if (value == '0)  return 3'b010;
    else                   return 3'b001;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: instruction input handshake, writeback port, and the
// decoded-operation output handshake toward the ALU.
//   master : upstream/ALU side (drives IR, writeback, out_ready)
//   slave  : the operand_fetch stage
interface operand_fetch_if;
  import lc3_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     ir;
  logic                  wb_en;
  logic [REG_W-1:0]      wb_dr;
  logic [DATA_W-1:0]     wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALUK_W-1:0]     aluk;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [REG_W-1:0]      dr;
  logic [NZP_W-1:0]      nzp;
  logic                  illegal;

  modport master (
    output in_valid, ir, wb_en, wb_dr, wb_data, out_ready,
    input  in_ready, out_valid, aluk, op_a, op_b, dr, nzp, illegal
  );

  modport slave (
    input  in_valid, ir, wb_en, wb_dr, wb_data, out_ready,
    output in_ready, out_valid, aluk, op_a, op_b, dr, nzp, illegal
  );

endinterface

// File: rtl/regfile8x16.sv
// 8x16 general register file: two asynchronous read ports, one synchronous
// write port, write-through bypass so a same-cycle write is seen by readers.
//   clk, rst_n    : clock, async active-low reset (clears all registers)
//   we, wa, wd    : write enable / address / data
//   ra_a, ra_b    : read addresses
//   rd_a, rd_b    : read data (bypassed)
module regfile8x16
  import lc3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_W-1:0]  ra_a,
  input  logic [REG_W-1:0]  ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs [NREG];

  // Storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // Read with write-through.
  assign rd_a = (we && (wa == ra_a)) ? wd : regs[ra_a];
  assign rd_b = (we && (wa == ra_b)) ? wd : regs[ra_b];

endmodule

// File: rtl/operand_fetch.sv
// LC-3 operand-fetch stage: decodes ADD/AND/NOT into ALU controls, fetches
// operands (with imm5 sign-extension), holds the result in a one-entry
// valid/ready output register, and owns the register file and NZP.
//   clk, rst_n : clock, async active-low reset
//   bus        : operand_fetch_if.slave (IR handshake, writeback, ALU output)
module operand_fetch
  import lc3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  operand_fetch_if.slave   bus
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  sr1;
  logic [REG_W-1:0]  sr2;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] imm;
  logic              legal;
  logic              accept;
  alu_op_t           op_d;
  alu_op_t           op_q;
  logic              out_valid_q;
  logic              illegal_q;
  logic [NZP_W-1:0]  nzp_q;

  assign opcode = bus.ir[15:12];
  assign sr1    = bus.ir[8:6];
  assign sr2    = bus.ir[2:0];
  assign imm    = {{(DATA_W-5){bus.ir[4]}}, bus.ir[4:0]};
  assign legal  = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);

  // Ready whenever the output slot is empty or draining this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  regfile8x16 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.wb_en),
    .wa    (bus.wb_dr),
    .wd    (bus.wb_data),
    .ra_a  (sr1),
    .ra_b  (sr2),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

  // Decode of the incoming instruction.
  always_comb begin
    op_d      = '0;
    op_d.op_a = rd_a;
    op_d.dr   = bus.ir[11:9];
    unique case (opcode)
      OP_ADD: begin
        op_d.aluk = ALUK_ADD;
        op_d.op_b = bus.ir[5] ? imm : rd_b;
      end
      OP_AND: begin
        op_d.aluk = ALUK_AND;
        op_d.op_b = bus.ir[5] ? imm : rd_b;
      end
      OP_NOT: begin
        op_d.aluk = ALUK_NOT;
        op_d.op_b = '0;
      end
      default: begin
        op_d.aluk = ALUK_ADD;
        op_d.op_b = '0;
      end
    endcase
  end

  // Output register, illegal pulse and condition codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      nzp_q       <= NZP_RESET;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && legal) begin
        op_q        <= op_d;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bus.wb_en) begin
        nzp_q <= nzp_of(bus.wb_data);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.aluk      = op_q.aluk;
  assign bus.op_a      = op_q.op_a;
  assign bus.op_b      = op_q.op_b;
  assign bus.dr        = op_q.dr;
  assign bus.nzp       = nzp_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

LC-3 operand-fetch stage sitting directly upstream of the ALU. It holds the 8×16 general register file and the NZP condition-code register, and decodes ADD/AND/NOT instructions into the ALU controls ALUK, OP_A and OP_B, including the imm5 sign-extension that the SR2MUX would otherwise perform. The decoded operation is held in a one-entry output register with a valid/ready handshake. Results return through a writeback port that updates both the register file and NZP.

## Interface
- DATA_W, 16, datapath width; the team only uses 16.
- NREG, 8, number of general registers; register index width is log2(NREG) = 3.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  IR holds an instruction.
- IN_READY  out  1  stage accepts IR this cycle.
- IR  in  16  LC-3 instruction word.
- WB_EN  in  1  write WB_DATA to R[WB_DR] and update NZP.
- WB_DR  in  3  writeback destination.
- WB_DATA  in  16  writeback value (ALU RESULT).
- OUT_VALID  out  1  decoded operation is valid.
- OUT_READY  in  1  ALU side consumes the operation.
- ALUK  out  2  00 ADD, 01 AND, 10 NOT.
- OP_A  out  16  R[SR1].
- OP_B  out  16  R[SR2], or SEXT(IR[4:0]).
- DR  out  3  destination register, IR[11:9].
- NZP  out  3  condition codes {N,Z,P}.
- ILLEGAL  out  1  one-cycle pulse when an unsupported opcode is accepted.

## Operation
- Field decode:
  - Opcode is IR[15:12].
  - SR1 = IR[8:6].
  - SR2 = IR[2:0].
  - Immediate mode is selected by IR[5].
- ADD (0001) and AND (0101):
  - ALUK = 00 for ADD, 01 for AND.
  - OP_A = R[SR1].
  - OP_B = IR[5] ? {{11{IR[4]}}, IR[4:0]} : R[SR2].
- NOT (1001):
  - ALUK = 10, OP_A = R[SR1], OP_B = 0.
  - IR[5:0] is ignored; no check is made for the 111111 pattern.
- Any other opcode:
  - Accepted and discarded; no output is produced.
  - ILLEGAL pulses high the cycle after acceptance.
- Accept condition: IN_VALID && IN_READY.
- IN_READY = !OUT_VALID || OUT_READY. This is combinational and gives full throughput with no bubble.
- Output register:
  - On accept of a legal opcode it loads ALUK/OP_A/OP_B/DR and sets OUT_VALID.
  - When OUT_READY is high and there is no new accept, OUT_VALID clears.
  - While OUT_VALID && !OUT_READY, all outputs hold stable.
- Writeback: when WB_EN is high, R[WB_DR] ← WB_DATA, and NZP is set as follows:
  - 100 if WB_DATA[15] is set;
  - 010 if WB_DATA == 0;
  - 001 otherwise.
- Bypass: if WB_EN is high and WB_DR equals SR1 (or SR2) in the accept cycle, the operand captured is WB_DATA, not the stale register.
- The stage has no scoreboard. Read-after-write distance greater than one cycle is the producer's responsibility.
- ADD overflow wraps mod 2^16; this is the ALU's concern, not this stage's.

## Timing
- Latency: an instruction accepted at edge k has OUT_VALID high after edge k.
- A register write at edge k is visible to a read at edge k via the bypass, and to any later read directly.
- Simultaneous accept and OUT_READY with OUT_VALID set: the old entry retires and the new one loads on the same edge.
- Simultaneous writeback and stall: the write completes. Held outputs are not refreshed; operands are snapshots taken at accept.
- Reset (asynchronous, RST_N low), effective immediately and also mid-handshake:
  - R0..R7 = 0;
  - OUT_VALID = 0, ALUK = 00, OP_A = 0, OP_B = 0, DR = 0;
  - NZP = 010;
  - ILLEGAL = 0.
- Reset release: IN_READY is high in the first cycle after release.

## Structure
- Package lc3_pkg holds:
  - opcode constants OP_ADD = 4'b0001, OP_AND = 4'b0101, OP_NOT = 4'b1001;
  - ALUK encodings ALUK_ADD = 2'b00, ALUK_AND = 2'b01, ALUK_NOT = 2'b10;
  - NZP reset value 3'b010.
- Sub-module regfile8x16:
  - two asynchronous read ports and one synchronous write port;
  - asynchronous active-low reset;
  - write-through bypass on both read ports.
- The top level holds decode, imm5 sign-extension, the output register/handshake, and NZP.

## Test plan
- Reset, then WB (R1 = 0x0005, R2 = 0x0003), then accept ADD R3,R1,R2 (IR = 0x1642) → ALUK = 00, OP_A = 0x0005, OP_B = 0x0003, DR = 3, one cycle after accept.
- AND immediate R4,R1,#-1 (IR = 0x587F) → ALUK = 01, OP_B = 0xFFFF. Then NOT R5,R1 (IR = 0x9A7F) → ALUK = 10, OP_B = 0.
- Hold OUT_READY = 0 for 3 cycles while IN_VALID = 1 → IN_READY = 0 and outputs stable. On release, back-to-back instructions issue one per cycle.
- Same-cycle WB_EN (WB_DR = 1, WB_DATA = 0x1234) and accept of ADD reading R1 → OP_A = 0x1234.
- WB_DATA = 0x8000 → NZP = 100; 0x0000 → 010; 0x0001 → 001. Asserting RST_N low mid-stall → OUT_VALID = 0 and NZP = 010 immediately.
- Accept IR = 0xF025 (TRAP) → ILLEGAL pulses for one cycle and OUT_VALID stays 0.
